oam_dma_ctrl: RTL and testbench
===============================

Name: oam_dma_ctrl

Overview:
- Sprite DMA controller for register $4014. A CPU write of page P to $4014 halts the CPU.
- It then takes over the CPU bus and copies 256 bytes from $PP00-$PPFF to the PPU OAM data port $2004.
- Sits between the CPU core and the bus decode. Its bus outputs feed the CPU/DMA address mux in front of the work-RAM adapter and the PPU register decode.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU write address that triggers DMA.
- OAM_DATA_ADDR, 16'h2004, destination address driven on every DMA write cycle.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset; synchronous and active-high
- i_cpu_ce  in  1  CPU-cycle enable, one i_clk pulse per CPU cycle
- i_cpu_addr  in  16  CPU bus address
- i_cpu_wdata  in  8  CPU write data
- i_cpu_wn  in  1  CPU write strobe, 0 = write
- o_cpu_rdy  out  1  CPU ready; 0 halts the CPU core on its next ce
- o_dma_busy  out  1  1 = DMA owns the bus; selects the o_dma_* signals in the bus mux
- o_dma_addr  out  16  DMA bus address
- o_dma_wdata  out  8  DMA write data
- o_dma_wn  out  1  DMA write strobe, 0 = write
- i_bus_rdata  in  8  bus read data, valid at the ce that ends a read cycle

Behaviour:
- Timing rule: all state, counter and parity registers update only on i_clk edges where i_cpu_ce=1. Between ce pulses they hold.
- Reset (i_rst=1, synchronous, overrides ce):
  - Outputs: state=IDLE, o_cpu_rdy=1, o_dma_busy=0, o_dma_addr=0, o_dma_wdata=0, o_dma_wn=1.
  - Internal: byte counter=0, page=0, data buffer=0, parity=0.
- Parity bit: toggles on every ce from reset; it counts CPU cycles.
- Trigger:
  - Condition: in IDLE, at a ce with i_cpu_addr==DMA_REG_ADDR and i_cpu_wn==0.
  - Action: latch page<=i_cpu_wdata, counter<=0, state<=HALT.
  - Any other address, or a read of DMA_REG_ADDR, is ignored.
- States:
  - IDLE: bus outputs at reset values; o_cpu_rdy=1.
  - HALT: one CPU cycle, bus not driven (o_dma_wn=1, addr=0). At the next ce: go to ALIGN if parity==1 (see macro), otherwise go to READ.
  - ALIGN: one dummy CPU cycle; then go to READ.
  - READ: o_dma_addr={page,counter}, o_dma_wn=1. At ce: buffer<=i_bus_rdata, go to WRITE.
  - WRITE: o_dma_addr=OAM_DATA_ADDR, o_dma_wdata=buffer, o_dma_wn=0. At ce: if counter==8'hFF go to IDLE, otherwise counter<=counter+1 and go to READ.
- Output decoding:
  - o_cpu_rdy=0 and o_dma_busy=1 in every state except IDLE.
  - All outputs are decoded from registered state, page, counter and buffer, so they are glitch-free and change only on clock edges.
- Length: exactly 256 byte pairs. The halt lasts 513 CPU cycles, or 514 when ALIGN is taken.
- Counter and address:
  - The counter is 8 bits and never wraps into page+1.
  - The source page is any value $00-$FF; no range check.
- Boundary cases:
  - While busy, CPU inputs are ignored, including another $4014 write; the CPU is halted and cannot legally issue one.
  - At the ce that ends the last WRITE, returning to IDLE and a new CPU write to $4014 cannot coincide. A trigger is only accepted in IDLE, i.e. at a later ce.
  - i_rst mid-transfer aborts immediately: IDLE on the next clock, bus released, rdy=1, partial OAM contents left as written.

Optional Feature:
- Macro OAM_DMA_ODD_ALIGN_EN.
- Defined: the ALIGN state is taken when parity==1 in HALT, giving cycle-accurate 513/514 halt length.
- Undefined: ALIGN is never entered and the halt is always 513 cycles. The parity register may be removed.

Test Plan:
- ce every 2 clocks; RAM $0200+n = n^8'h5A; write $02 to $4014 with parity=0 -> rdy low for exactly 513 ce; 256 writes to $2004 with data n^8'h5A in order n=0..255; rdy=1 and busy=0 after.
- Same stimulus with parity=1, macro defined -> 514 ce halted; first READ addr $0200 occurs one ce later. Macro undefined -> 513 ce.
- Writes to $4013 and $4015, and a read of $4014 -> no trigger; rdy stays 1, busy stays 0, o_dma_wn stays 1.
- i_rst asserted after the 100th $2004 write -> next clock: IDLE, rdy=1, busy=0, o_dma_wn=1, o_dma_addr=0. A new $4014 write of $03 -> fresh transfer starting at $0300.
- Page $FF with irregular ce (gaps of 1-4 clocks) -> read addresses $FF00..$FFFF with no wrap to $0000. Outputs stable between ce pulses. 256 writes.
- A $4014 write attempted while busy, forced on the CPU inputs -> ignored: page unchanged, counter sequence uninterrupted.

Source files
------------

// File: rtl/oam_dma_ctrl.sv
// rtl/oam_dma_ctrl.sv - $4014 sprite DMA controller, odd-cycle alignment under OAM_DMA_ODD_ALIGN_EN
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cpu_ce,
  input  logic [15:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_wdata,
  input  logic        i_cpu_wn,
  output logic        o_cpu_rdy,
  output logic        o_dma_busy,
  output logic [15:0] o_dma_addr,
  output logic [7:0]  o_dma_wdata,
  output logic        o_dma_wn,
  input  logic [7:0]  i_bus_rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  page;
  logic [7:0]  counter;
  logic [7:0]  buffer;
  logic        trigger_hit;

  // A CPU write to the DMA register; only meaningful while idle.
  assign trigger_hit = (i_cpu_addr == DMA_REG_ADDR) && !i_cpu_wn;

`ifdef OAM_DMA_ODD_ALIGN_EN
  logic parity;

  // CPU-cycle parity, used to pick up the extra alignment cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      parity <= 1'b0;
    end else if (i_cpu_ce) begin
      parity <= ~parity;
    end
  end
`endif

  // State register advances once per CPU cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else if (i_cpu_ce) begin
      state <= state_nxt;
    end
  end

  // Next-state selection and bus output decode from registered state.
  always_comb begin
    state_nxt   = state;
    o_cpu_rdy   = 1'b0;
    o_dma_busy  = 1'b1;
    o_dma_addr  = 16'h0000;
    o_dma_wdata = 8'h00;
    o_dma_wn    = 1'b1;
    case (state)
      S_IDLE: begin
        o_cpu_rdy  = 1'b1;
        o_dma_busy = 1'b0;
        if (trigger_hit) begin
          state_nxt = S_HALT;
        end
      end
      S_HALT: begin
`ifdef OAM_DMA_ODD_ALIGN_EN
        state_nxt = parity ? S_ALIGN : S_READ;
`else
        state_nxt = S_READ;
`endif
      end
      S_ALIGN: begin
        state_nxt = S_READ;
      end
      S_READ: begin
        o_dma_addr = {page, counter};
        state_nxt  = S_WRITE;
      end
      S_WRITE: begin
        o_dma_addr  = OAM_DATA_ADDR;
        o_dma_wdata = buffer;
        o_dma_wn    = 1'b0;
        state_nxt   = (counter == 8'hFF) ? S_IDLE : S_READ;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Page latch, byte counter and read buffer; counter stays inside the page.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      page    <= 8'h00;
      counter <= 8'h00;
      buffer  <= 8'h00;
    end else if (i_cpu_ce) begin
      case (state)
        S_IDLE: begin
          if (trigger_hit) begin
            page    <= i_cpu_wdata;
            counter <= 8'h00;
          end
        end
        S_READ: begin
          buffer <= i_bus_rdata;
        end
        S_WRITE: begin
          if (counter != 8'hFF) begin
            counter <= counter + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb/tb_oam_dma_ctrl.sv - scoreboard bench for oam_dma_ctrl
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_wn;
  logic        rdy;
  logic        busy;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_wn;
  logic [7:0]  bus_rdata;

  typedef struct packed {
    logic [15:0] addr;
    logic        wn;
    logic [7:0]  wdata;
  } cyc_t;

  cyc_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          ce_cnt = 0;
  int          halt_cnt = 0;
  int          wr_cnt = 0;
  logic        last_ce = 1'b1;
  logic [26:0] prev_snap = '0;
  logic        irregular = 1'b0;

  always #5 clk = ~clk;

  oam_dma_ctrl dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cpu_ce    (ce),
    .i_cpu_addr  (cpu_addr),
    .i_cpu_wdata (cpu_wdata),
    .i_cpu_wn    (cpu_wn),
    .o_cpu_rdy   (rdy),
    .o_dma_busy  (busy),
    .o_dma_addr  (dma_addr),
    .o_dma_wdata (dma_wdata),
    .o_dma_wn    (dma_wn),
    .i_bus_rdata (bus_rdata)
  );

  function automatic logic [7:0] src_byte(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ a[15:8] ^ 8'h02;
  endfunction

  assign bus_rdata = src_byte(dma_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      last_ce = ce | rst;
    end
  end

  initial begin
    cyc_t e;
    logic [26:0] snap;
    forever begin
      @(negedge clk);
      snap = {rdy, busy, dma_addr, dma_wdata, dma_wn};
      if (!rst) begin
        if (!last_ce) chk("stable", {5'd0, snap}, {5'd0, prev_snap});
        if (ce) begin
          if (rdy === 1'b0) halt_cnt++;
          if (busy) begin
            chk("rdy_low", {31'd0, rdy}, 32'd0);
            chk("q_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              chk("bus_addr", {16'd0, dma_addr}, {16'd0, e.addr});
              chk("bus_wn", {31'd0, dma_wn}, {31'd0, e.wn});
              if (e.wn == 1'b0) begin
                chk("bus_wdata", {24'd0, dma_wdata}, {24'd0, e.wdata});
                wr_cnt++;
              end
            end
          end else begin
            chk("idle_rdy", {31'd0, rdy}, 32'd1);
            chk("idle_wn", {31'd0, dma_wn}, 32'd1);
            chk("idle_addr", {16'd0, dma_addr}, 32'd0);
          end
        end
      end
      prev_snap = snap;
    end
  end

  function automatic int next_gap();
    return irregular ? int'($urandom_range(1, 4)) : 2;
  endfunction

  task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input logic w);
    int gap;
    gap = next_gap();
    cpu_addr = a;
    cpu_wdata = d;
    cpu_wn = w;
    ce = 1'b0;
    repeat (gap - 1) begin
      @(posedge clk);
      #1;
    end
    ce = 1'b1;
    @(posedge clk);
    #1;
    ce = 1'b0;
    if (!rst) ce_cnt++;
  endtask

  task automatic set_parity(input int want);
    if (((ce_cnt + 1) % 2) != want) cpu_cycle(16'h0000, 8'h00, 1'b1);
  endtask

  task automatic run_dma(input logic [7:0] pg, input logic poke, input int abort_at);
    logic align;
    int   exp_halt;
    cyc_t e;
`ifdef OAM_DMA_ODD_ALIGN_EN
    align = (((ce_cnt + 1) % 2) == 1);
`else
    align = 1'b0;
`endif
    exp_halt = align ? 514 : 513;
    e = '{addr: 16'h0000, wn: 1'b1, wdata: 8'h00};
    exp_q.push_back(e);
    if (align) exp_q.push_back(e);
    for (int n = 0; n < 256; n++) begin
      e = '{addr: {pg, 8'(n)}, wn: 1'b1, wdata: 8'h00};
      exp_q.push_back(e);
      e = '{addr: 16'h2004, wn: 1'b0, wdata: src_byte({pg, 8'(n)})};
      exp_q.push_back(e);
    end
    halt_cnt = 0;
    wr_cnt = 0;
    cpu_cycle(16'h4014, pg, 1'b0);
    chk("trig_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 700 && busy; i++) begin
      if (abort_at != 0 && wr_cnt == abort_at) break;
      if (poke) cpu_cycle(16'h4014, 8'h77, 1'b0);
      else cpu_cycle(16'h0000, 8'h00, 1'b1);
    end
    if (abort_at != 0) begin
      chk("abort_point", wr_cnt, abort_at);
      return;
    end
    chk("done_busy", {31'd0, busy}, 32'd0);
    chk("done_rdy", {31'd0, rdy}, 32'd1);
    chk("halt_len", halt_cnt, exp_halt);
    chk("writes", wr_cnt, 256);
    chk("q_drained", exp_q.size(), 0);
    cpu_cycle(16'h0000, 8'h00, 1'b1);
    chk("post_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    ce = 1'b1;
    cpu_addr = 16'h0000;
    cpu_wdata = 8'h00;
    cpu_wn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", {31'd0, rdy}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_addr", {16'd0, dma_addr}, 32'd0);
    chk("rst_wdata", {24'd0, dma_wdata}, 32'd0);
    chk("rst_wn", {31'd0, dma_wn}, 32'd1);
    rst = 1'b0;
    ce = 1'b0;
    ce_cnt = 0;

    cpu_cycle(16'h4013, 8'h02, 1'b0);
    chk("nt4013_busy", {31'd0, busy}, 32'd0);
    cpu_cycle(16'h4015, 8'h02, 1'b0);
    chk("nt4015_busy", {31'd0, busy}, 32'd0);
    cpu_cycle(16'h4014, 8'h02, 1'b1);
    chk("ntrd_busy", {31'd0, busy}, 32'd0);
    chk("ntrd_rdy", {31'd0, rdy}, 32'd1);
    chk("ntrd_wn", {31'd0, dma_wn}, 32'd1);
    cpu_cycle(16'h0000, 8'h00, 1'b1);

    set_parity(0);
    run_dma(8'h02, 1'b0, 0);

    set_parity(1);
    run_dma(8'h02, 1'b0, 0);

    run_dma(8'h05, 1'b1, 0);

    run_dma(8'h02, 1'b0, 100);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_rdy", {31'd0, rdy}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_wn", {31'd0, dma_wn}, 32'd1);
    chk("abort_addr", {16'd0, dma_addr}, 32'd0);
    exp_q.delete();
    rst = 1'b0;
    ce_cnt = 0;
    run_dma(8'h03, 1'b0, 0);

    irregular = 1'b1;
    run_dma(8'hFF, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
